// File: rtl/tsp_program_loader.sv
//-----------------------------------------------------------------------------
// tsp_program_loader
//
// Writer side of the TSP instruction-memory interface. A host bridge streams
// 32-bit instruction words in. The loader writes them one after another into
// TSP instruction memory, starting at address 0. While a load is in progress
// the TSP core is held in reset. It is released once the final word has been
// committed to memory.
//
// Handshake (host -> loader): a word moves when s_valid && s_ready are both
// high at a rising clock edge. s_ready depends only on the state register.
// There is no path from s_valid to s_ready. Until a word is accepted, the host
// keeps s_valid and s_data steady.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   load_start      single-cycle request to begin a load (IDLE or RUN only)
//   load_len        word count for the load, sampled with load_start
//   load_abort      single-cycle abort, honoured only while loading
//   s_valid/s_data  host instruction word stream
//   s_ready         loader accepts a word this cycle (state == LOAD)
//   mem_we/addr/wdata  registered instruction-memory write port
//   tsp_rst         TSP core reset (high except while running)
//   tsp_run         TSP core released and running
//   busy            loading or committing the final word
//   done            one-cycle pulse in the first running cycle
//   error           sticky: bad length or abort; cleared by an accepted start
//   word_count      words accepted in the current / most recent load
//   dbg_state       current FSM state (IDLE=0, LOAD=1, DONE=2, RUN=3)
//-----------------------------------------------------------------------------
module tsp_program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  load_abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  tsp_rst,
  output logic                  tsp_run,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Memory capacity. It needs one more bit than an address, which is why
  // load_len and word_count are ADDR_WIDTH+1 bits wide.
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] count_next;
  logic                len_ok;

  // A length of 1..MAX_WORDS is accepted. Because longer loads are refused
  // here, the write address never has to wrap.
  assign len_ok     = (load_len != '0) && (load_len <= MAX_WORDS);
  assign count_next = word_count + ONE;

  // Decoded from the state register only.
  assign s_ready   = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD) || (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tsp_rst    <= 1'b1;
      tsp_run    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Write strobe and completion pulse are single-cycle by default.
      mem_we <= 1'b0;
      done   <= 1'b0;

      case (state)
        ST_IDLE: begin
          tsp_rst <= 1'b1;
          tsp_run <= 1'b0;
          if (load_start) begin
            if (len_ok) begin
              len_q      <= load_len;
              word_count <= '0;
              error      <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // If an abort and a handshake land in the same cycle, the abort
          // wins. s_ready was already high, but the word is dropped: it is
          // neither written nor counted.
          if (load_abort) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end else if (s_valid) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_WIDTH-1:0];
            mem_wdata  <= s_data;
            word_count <= count_next;
            if (count_next == len_q) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // The final write is on the memory port during this cycle. The
          // core is released at the end of it, so it never fetches a word
          // that has not been written yet.
          tsp_rst <= 1'b0;
          tsp_run <= 1'b1;
          done    <= 1'b1;
          state   <= ST_RUN;
        end

        ST_RUN: begin
          if (load_start) begin
            if (len_ok) begin
              len_q      <= load_len;
              word_count <= '0;
              error      <= 1'b0;
              tsp_rst    <= 1'b1;
              tsp_run    <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Invariants of the loader.
  // A write always falls inside the length that was latched.
  a_addr_in_len: assert property (@(posedge clk) disable iff (rst)
    mem_we |-> ({1'b0, mem_addr} < len_q));

  // The count never runs past the latched length.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    word_count <= len_q);

  // The completion pulse coincides with the core's release.
  a_done_release: assert property (@(posedge clk) disable iff (rst)
    done |-> (tsp_run && !tsp_rst));

  // The core is never in reset and running at the same time.
  a_rst_run_excl: assert property (@(posedge clk) disable iff (rst)
    !(tsp_rst && tsp_run));

endmodule

// File: tb/tb_tsp_program_loader.sv
module tb_tsp_program_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W  = AW + DW;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_abort;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          tsp_rst;
  logic          tsp_run;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  bit running = 1'b0;

  tsp_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_abort(load_abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .tsp_rst(tsp_rst), .tsp_run(tsp_run),
    .busy(busy), .done(done), .error(error), .word_count(word_count),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every memory write must match the oldest word the
  // model expects.
  logic [W-1:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write at %0t",
                   mem_addr, mem_wdata, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== mon_e) begin
            failures++;
            $display("FAIL mem_write: got addr=%0h data=%0h expected addr=%0h data=%0h at %0t",
                     mem_addr, mem_wdata, mon_e[W-1:DW], mon_e[DW-1:0], $time);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values();
    chk("rst_tsp_rst", tsp_rst, 1);
    chk("rst_tsp_run", tsp_run, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_busy", busy, 0);
  endtask

  // Called and returns at posedge+1.
  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len = len[AW:0];
    @(posedge clk); #1;
    load_start = 1'b0;
    if (len >= 1 && len <= MAXW) begin
      running = 1'b0;
      chk("start_s_ready", s_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_word_count", word_count, 0);
      chk("start_error", error, 0);
      chk("start_tsp_rst", tsp_rst, 1);
      chk("start_tsp_run", tsp_run, 0);
    end else begin
      chk("badlen_error", error, 1);
      chk("badlen_s_ready", s_ready, 0);
      chk("badlen_busy", busy, 0);
      chk("badlen_tsp_run", tsp_run, running);
      chk("badlen_tsp_rst", tsp_rst, !running);
    end
  endtask

  // Streams n words. Word index abort_at (if >= 0) is presented with
  // load_abort and ends the load. If poke is set, a stray load_start is
  // issued during the second handshake and must be ignored.
  task automatic send_words(input int n, input int abort_at, input logic [31:0] base,
                            input int gmin, input int gmax, input bit poke);
    for (int i = 0; i < n; i++) begin
      int budget;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      d = (base != 0) ? base + i : $urandom();
      a = i[AW-1:0];
      s_data = d;
      s_valid = 1'b1;
      budget = 0;
      while (s_ready !== 1'b1 && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (s_ready !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL s_ready_timeout: got s_ready=%b expected 1 within 20 cycles", s_ready);
        s_valid = 1'b0;
        return;
      end
      if (i == abort_at) load_abort = 1'b1;
      else exp_q.push_back({a, d});
      if (poke && i == 1) begin
        load_start = 1'b1;
        load_len = 1;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      load_abort = 1'b0;
      load_start = 1'b0;
      if (i == abort_at) begin
        running = 1'b0;
        chk("abort_s_ready", s_ready, 0);
        chk("abort_error", error, 1);
        chk("abort_tsp_rst", tsp_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_word_count", word_count, i);
        return;
      end
      if (i < n - 1) repeat ($urandom_range(gmin, gmax)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Entered at posedge+1 right after the final handshake edge.
  task automatic finish_check(input int len);
    @(negedge clk);
    chk("commit_done", done, 0);
    chk("commit_busy", busy, 1);
    chk("commit_s_ready", s_ready, 0);
    chk("commit_tsp_rst", tsp_rst, 1);
    @(negedge clk);
    chk("run_done_pulse", done, 1);
    chk("run_tsp_rst", tsp_rst, 0);
    chk("run_tsp_run", tsp_run, 1);
    chk("run_busy", busy, 0);
    chk("run_word_count", word_count, len);
    chk("run_error", error, 0);
    chk("run_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("run_done_cleared", done, 0);
    chk("run_still_running", tsp_run, 1);
    running = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    load_len = '0;
    load_abort = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    #3;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back load of A0..A3
    start_load(4);
    send_words(4, -1, 32'hA0, 0, 0, 1'b0);
    finish_check(4);

    // Abort outside LOAD is ignored
    load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
    chk("idle_abort_run", tsp_run, 1);
    chk("idle_abort_error", error, 0);

    // Re-entry from RUN, host valid toggling 1,0,1,0,1
    start_load(3);
    send_words(3, -1, 0, 1, 1, 1'b0);
    finish_check(3);

    // Abort on the third handshake of an 8-word load
    start_load(8);
    send_words(3, 2, 0, 0, 2, 1'b0);

    // Invalid lengths in IDLE, then a good one-word load
    start_load(0);
    start_load(MAXW + 1);
    start_load(1);
    send_words(1, -1, 0, 0, 0, 1'b0);
    finish_check(1);

    // Invalid length while running, then random loads
    start_load(0);
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 24);
      start_load(len);
      send_words(len, -1, 0, 0, 3, k[0]);
      finish_check(len);
    end

    // Full capacity: last write lands at MAX_WORDS-1
    start_load(MAXW);
    send_words(MAXW, -1, 0, 0, 0, 1'b0);
    finish_check(MAXW);

    // Asynchronous reset in the middle of a load
    start_load(10);
    send_words(5, -1, 0, 0, 1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    running = 1'b0;
    check_reset_values();
    chk("midrst_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    start_load(2);
    send_words(2, -1, 0, 0, 2, 1'b0);
    finish_check(2);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
